// File: rtl/semseg_capture.sv
// Receive side of the multiplexed seven-segment link. Resynchronises the
// anode/cathode bus, waits for it to settle, and rebuilds one active-high
// segment pattern per digit. Reports complete frames, anode bus faults and
// a scanner that has stopped producing valid digits.
module semseg_capture #(
    parameter int SEMSEGS_NUM    = 8,
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                            clk_i,
    input  logic                            arstn_i,
    input  logic [6:0]                      seg_i,
    input  logic [SEMSEGS_NUM-1:0]          an_i,
    input  logic                            clr_err_i,
    output logic [SEMSEGS_NUM-1:0][6:0]     digits_o,
    output logic [SEMSEGS_NUM-1:0]          valid_mask_o,
    output logic                            frame_valid_o,
    output logic                            error_o,
    output logic                            stale_o
);
    localparam int W  = SEMSEGS_NUM + 7;
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [W-1:0]           sync_q, s_q, p_q;
    logic [CW-1:0]          cnt_q;
    logic [TW-1:0]          tcnt_q;
    logic [SEMSEGS_NUM-1:0] an_low, new_mask;
    logic                   strobe, multi_cold, one_cold, capture, bad;

    // Anodes are active-low: a set bit in an_low marks a lit digit.
    assign an_low     = ~s_q[W-1:7];
    // One strobe per stable window: the counter saturates past the trigger value.
    assign strobe     = (s_q == p_q) && (cnt_q == CW'(STABLE_CYCLES - 1));
    assign multi_cold = (an_low & (an_low - SEMSEGS_NUM'(1))) != '0;
    assign one_cold   = (an_low != '0) && !multi_cold;
    assign capture    = strobe && one_cold;
    assign bad        = strobe && multi_cold;
    assign new_mask   = valid_mask_o | an_low;
    assign stale_o    = (tcnt_q == TW'(TIMEOUT_CYCLES));

    // Two-flop synchroniser plus one delayed copy for change detection;
    // resets to the idle (all-high) bus level.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            sync_q <= '1;
            s_q    <= '1;
            p_q    <= '1;
        end else begin
            sync_q <= {an_i, seg_i};
            s_q    <= sync_q;
            p_q    <= s_q;
        end
    end

    // Stability counter: restarts on any bus change, saturates at STABLE_CYCLES.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i)
            cnt_q <= '0;
        else if (s_q != p_q)
            cnt_q <= '0;
        else if (cnt_q != CW'(STABLE_CYCLES))
            cnt_q <= cnt_q + CW'(1);
    end

    // Digit capture, mask tracking and the frame pulse; the completing digit
    // is written on the same edge that raises the pulse and clears the mask.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            digits_o      <= '0;
            valid_mask_o  <= '0;
            frame_valid_o <= 1'b0;
        end else begin
            frame_valid_o <= 1'b0;
            if (capture) begin
                for (int k = 0; k < SEMSEGS_NUM; k++)
                    if (an_low[k]) digits_o[k] <= ~s_q[6:0];
                if (&new_mask) begin
                    frame_valid_o <= 1'b1;
                    valid_mask_o  <= '0;
                end else begin
                    valid_mask_o  <= new_mask;
                end
            end
        end
    end

    // Sticky bus-fault flag; a fault arriving with a clear keeps the flag set.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i)
            error_o <= 1'b0;
        else if (bad)
            error_o <= 1'b1;
        else if (clr_err_i)
            error_o <= 1'b0;
    end

    // Cycles since the last valid capture, saturating at the timeout value.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i)
            tcnt_q <= '0;
        else if (capture)
            tcnt_q <= '0;
        else if (tcnt_q != TW'(TIMEOUT_CYCLES))
            tcnt_q <= tcnt_q + TW'(1);
    end

endmodule

// File: tb/tb_semseg_capture.sv
// Bench for semseg_capture: directed scenarios plus randomized bus traffic,
// checked against an input-history reference model (a value held for
// STABLE_CYCLES+1 samples takes effect two edges later).
module tb_semseg_capture;
    localparam int N  = 8;
    localparam int SC = 4;
    localparam int TO = 64;

    logic             clk = 1'b0;
    logic             arstn = 1'b0;
    logic [6:0]       seg = '1;
    logic [N-1:0]     an = '1;
    logic             clr = 1'b0;
    logic [N-1:0][6:0] digits;
    logic [N-1:0]     mask;
    logic             fv, err, stale;

    semseg_capture #(.SEMSEGS_NUM(N), .STABLE_CYCLES(SC), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk), .arstn_i(arstn), .seg_i(seg), .an_i(an), .clr_err_i(clr),
        .digits_o(digits), .valid_mask_o(mask), .frame_valid_o(fv),
        .error_o(err), .stale_o(stale)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    // reference model state
    logic [N+6:0]      m_last, m_p1, m_p2;
    logic              m_p1v, m_p2v;
    int                m_run, m_since, m_fv, dut_fv;
    logic [N-1:0][6:0] m_dig, fv_dig;
    logic [N-1:0]      m_mask;
    logic              m_err;

    task automatic model_reset();
        m_last = '1; m_run = 1000; m_p1v = 0; m_p2v = 0; m_p1 = '0; m_p2 = '0;
        m_dig = '0; m_mask = '0; m_err = 0; m_since = 0;
    endtask

    // One clock: advance the model with the inputs held over this edge,
    // then record what the DUT shows just after the edge.
    task automatic step();
        logic [N+6:0] cur, act;
        logic act_v, captured, set;
        int zeros, k;
        @(posedge clk);
        if (arstn) begin
            cur = {an, seg};
            act = m_p2; act_v = m_p2v;
            m_p2 = m_p1; m_p2v = m_p1v;
            if (cur == m_last) begin
                if (m_run < 1000) m_run++;
            end else begin
                m_last = cur; m_run = 1;
            end
            m_p1v = (m_run == SC + 1); m_p1 = cur;
            captured = 0; set = 0;
            if (act_v) begin
                zeros = 0; k = 0;
                for (int i = 0; i < N; i++)
                    if (!act[7+i]) begin zeros++; k = i; end
                if (zeros == 1) begin
                    m_dig[k] = ~act[6:0];
                    captured = 1;
                    if ((m_mask | (N'(1) << k)) == '1) begin
                        m_mask = '0; m_fv++;
                    end else begin
                        m_mask = m_mask | (N'(1) << k);
                    end
                end else if (zeros > 1) begin
                    set = 1;
                end
            end
            if (set) m_err = 1;
            else if (clr) m_err = 0;
            if (captured) m_since = 0;
            else if (m_since < TO) m_since++;
        end
        #1;
        if (arstn && fv) begin dut_fv++; fv_dig = digits; end
    endtask

    task automatic hold(input logic [N-1:0] a, input logic [6:0] s, input int n);
        an = a; seg = s;
        repeat (n) step();
    endtask

    function automatic logic [N-1:0] cold(input int k);
        return ~(N'(1) << k);
    endfunction

    task automatic test_reset();
        arstn = 0; an = '1; seg = '1; clr = 0;
        model_reset(); m_fv = 0; dut_fv = 0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (digits !== '0) begin n_fail++; $display("FAIL reset_digits got=%h exp=0", digits); end
        n_cmp++; if (mask !== '0) begin n_fail++; $display("FAIL reset_mask got=%h exp=0", mask); end
        n_cmp++; if ({fv, err, stale} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got=%b exp=000", {fv, err, stale}); end
        arstn = 1;
        step();
    endtask

    task automatic test_scan();
        int f0;
        f0 = dut_fv;
        for (int k = 0; k < N; k++) hold(cold(k), ~(7'h3F + 7'(k)), 1000);
        for (int k = 0; k < N; k++) begin
            n_cmp++;
            if (digits[k] !== 7'h3F + 7'(k)) begin
                n_fail++; $display("FAIL scan_digit%0d got=%h exp=%h", k, digits[k], 7'h3F + 7'(k));
            end
        end
        n_cmp++; if (dut_fv - f0 != 1) begin n_fail++; $display("FAIL scan_pulses got=%0d exp=1", dut_fv - f0); end
        n_cmp++; if (mask !== '0) begin n_fail++; $display("FAIL scan_mask got=%h exp=0", mask); end
        n_cmp++; if (fv_dig[N-1] !== 7'h46) begin n_fail++; $display("FAIL scan_last_with_pulse got=%h exp=46", fv_dig[N-1]); end
    endtask

    task automatic test_glitch();
        logic [6:0] pat, gp;
        int k;
        hold(8'hFE, ~7'h06, 20);
        hold(8'hFE, 7'h00, 3);
        hold(8'hFE, ~7'h06, 20);
        n_cmp++; if (digits[0] !== 7'h06) begin n_fail++; $display("FAIL glitch_digit0 got=%h exp=06", digits[0]); end
        for (int r = 0; r < 8; r++) begin
            k = $urandom_range(N - 1);
            pat = 7'($urandom);
            gp = pat ^ 7'($urandom_range(127, 1));
            hold(cold(k), ~pat, 12);
            hold(cold(k), ~gp, $urandom_range(SC, 1));
            hold(cold(k), ~pat, 12);
            n_cmp++; if (digits[k] !== pat) begin n_fail++; $display("FAIL glitch_rand_digit%0d got=%h exp=%h", k, digits[k], pat); end
        end
        n_cmp++; if (digits !== m_dig) begin n_fail++; $display("FAIL glitch_model got=%h exp=%h", digits, m_dig); end
        n_cmp++; if (dut_fv != m_fv) begin n_fail++; $display("FAIL glitch_pulses got=%0d exp=%0d", dut_fv, m_fv); end
    endtask

    task automatic test_error();
        logic [N-1:0][6:0] d0;
        logic [N-1:0] mk0;
        int i, j;
        d0 = digits; mk0 = mask;
        hold(8'hFC, 7'($urandom), 10);
        n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_set got=%b exp=1", err); end
        n_cmp++; if (digits !== d0) begin n_fail++; $display("FAIL err_digits got=%h exp=%h", digits, d0); end
        n_cmp++; if (mask !== mk0) begin n_fail++; $display("FAIL err_mask got=%h exp=%h", mask, mk0); end
        clr = 1; step(); clr = 0;
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_clear got=%b exp=0", err); end
        // new fault strobe lands on the 7th edge while clear is held
        i = $urandom_range(N - 1, 2);
        j = (i == 2) ? 3 : 2;
        an = cold(i) & cold(j); seg = 7'($urandom); clr = 1;
        repeat (7) step();
        n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_set_wins got=%b exp=1", err); end
        step();
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_clear_after got=%b exp=0", err); end
        clr = 0;
        n_cmp++; if (m_err !== err) begin n_fail++; $display("FAIL err_model got=%b exp=%b", err, m_err); end
    endtask

    task automatic test_stale();
        int k;
        k = $urandom_range(N - 1);
        hold('1, '1, 2);
        hold(cold(k), 7'($urandom), 7);
        an = '1; seg = 7'($urandom);
        for (int c = 1; c <= 70; c++) begin
            step();
            n_cmp++;
            if (stale !== (c >= TO)) begin
                n_fail++; $display("FAIL stale_c%0d got=%b exp=%b", c, stale, (c >= TO));
            end
        end
        hold(cold(k ^ 1), 7'($urandom), 7);
        n_cmp++; if (stale !== 1'b0) begin n_fail++; $display("FAIL stale_recover got=%b exp=0", stale); end
    endtask

    task automatic test_reset_mid();
        logic [6:0] pats [N];
        int f0;
        for (int k = 0; k < 4; k++) hold(cold(k), 7'($urandom), 8);
        n_cmp++; if (mask !== m_mask) begin n_fail++; $display("FAIL mid_mask got=%h exp=%h", mask, m_mask); end
        arstn = 0; model_reset();
        @(posedge clk); #1;
        n_cmp++; if ({digits, mask, fv, err, stale} !== '0) begin
            n_fail++; $display("FAIL mid_reset got=%h/%h/%b%b%b exp=0", digits, mask, fv, err, stale);
        end
        arstn = 1;
        f0 = dut_fv;
        for (int k = 0; k < N; k++) begin
            pats[k] = 7'($urandom);
            hold(cold(k), ~pats[k], $urandom_range(12, 7));
        end
        n_cmp++; if (dut_fv - f0 != 1) begin n_fail++; $display("FAIL mid_pulses got=%0d exp=1", dut_fv - f0); end
        for (int k = 0; k < N; k++) begin
            n_cmp++;
            if (digits[k] !== pats[k]) begin n_fail++; $display("FAIL mid_digit%0d got=%h exp=%h", k, digits[k], pats[k]); end
        end
    endtask

    task automatic test_recapture();
        logic [6:0] pa, pb;
        int f0;
        f0 = dut_fv;
        pa = 7'($urandom); pb = pa ^ 7'($urandom_range(127, 1));
        hold(cold(0), 7'($urandom), 8);
        hold(cold(1), 7'($urandom), 8);
        hold(cold(2), ~pa, 8);
        hold(cold(3), 7'($urandom), 8);
        hold(cold(2), ~pb, 8);
        n_cmp++; if (mask !== 8'h0F) begin n_fail++; $display("FAIL recap_mask got=%h exp=0f", mask); end
        for (int k = 4; k < N; k++) hold(cold(k), 7'($urandom), 8);
        n_cmp++; if (digits[2] !== pb) begin n_fail++; $display("FAIL recap_digit2 got=%h exp=%h", digits[2], pb); end
        n_cmp++; if (dut_fv - f0 != 1) begin n_fail++; $display("FAIL recap_pulses got=%0d exp=1", dut_fv - f0); end
    endtask

    task automatic test_back_to_back();
        int sel, i, j;
        logic [N-1:0] a;
        for (int r = 0; r < 300; r++) begin
            sel = $urandom_range(9);
            i = $urandom_range(N - 1);
            j = (i + $urandom_range(N - 1, 1)) % N;
            if (sel < 7) a = cold(i);
            else if (sel == 7) a = '1;
            else if (sel == 8) a = cold(i) & cold(j);
            else a = 8'($urandom);
            clr = ($urandom_range(15) == 0);
            hold(a, 7'($urandom), $urandom_range(10, 1));
            clr = 0;
            if (r % 25 == 24) begin
                n_cmp++; if (digits !== m_dig) begin n_fail++; $display("FAIL b2b_digits r%0d got=%h exp=%h", r, digits, m_dig); end
                n_cmp++; if (mask !== m_mask) begin n_fail++; $display("FAIL b2b_mask r%0d got=%h exp=%h", r, mask, m_mask); end
                n_cmp++; if (err !== m_err) begin n_fail++; $display("FAIL b2b_err r%0d got=%b exp=%b", r, err, m_err); end
                n_cmp++; if (stale !== (m_since == TO)) begin n_fail++; $display("FAIL b2b_stale r%0d got=%b exp=%b", r, stale, (m_since == TO)); end
            end
        end
        n_cmp++; if (dut_fv != m_fv) begin n_fail++; $display("FAIL b2b_pulses got=%0d exp=%0d", dut_fv, m_fv); end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_glitch();
        test_error();
        test_stale();
        test_reset_mid();
        test_recapture();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
